// File: rtl/fwd_pkg.sv
// Shared types for the ID-stage forwarding scoreboard: in-flight entry record
// and the position-based readiness rule for ALU versus load results.
package fwd_pkg;

  // Entry addresses are stored zero-extended; modules support AW up to this width.
  localparam int ENTRY_AW          = 16;
  localparam int ALU_READY_POS_DEF = 1;
  localparam int LD_READY_POS_DEF  = 2;

  typedef struct packed {
    logic                valid;
    logic [ENTRY_AW-1:0] addr;
    logic                load;
  } entry_t;

  function automatic logic ready(input int   pos,
                                 input logic load,
                                 input int   alu_pos = ALU_READY_POS_DEF,
                                 input int   ld_pos  = LD_READY_POS_DEF);
    return pos >= (load ? ld_pos : alu_pos);
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// One read port of the forwarding scoreboard: finds the youngest in-flight
// writer of rd_addr and either forwards its stage data or requests a stall.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int DEPTH         = 3,
  parameter int AW            = 5,
  parameter int DW            = 32,
  parameter int ALU_READY_POS = ALU_READY_POS_DEF,
  parameter int LD_READY_POS  = LD_READY_POS_DEF
) (
  input  entry_t [DEPTH-1:0]    entries,
  input  logic   [AW-1:0]       rd_addr,
  input  logic   [DW-1:0]       rf_data,
  input  logic   [DEPTH*DW-1:0] stage_data,
  output logic   [DW-1:0]       data,
  output logic                  hit,
  output logic                  needs_stall
);

  logic found;

  // Only the youngest match counts; an older ready copy is stale whenever a
  // younger writer of the same register is still in flight.
  always_comb begin
    found       = 1'b0;
    hit         = 1'b0;
    needs_stall = 1'b0;
    data        = rf_data;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && entries[k].valid && (rd_addr != '0) &&
          (entries[k].addr == ENTRY_AW'(rd_addr))) begin
        found = 1'b1;
        if (ready(k, entries[k].load, ALU_READY_POS, LD_READY_POS)) begin
          hit  = 1'b1;
          data = stage_data[k*DW +: DW];
        end else begin
          needs_stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_forwarding_scoreboard.sv
// ID-stage operand forwarding with load-aware stall over DEPTH tracked stages.
// Optional FWD_STATS_EN adds saturating stall / forward event counters.
module id_forwarding_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_READ      = 2,
  parameter int DEPTH         = 3,
  parameter int AW            = 5,
  parameter int DW            = 32,
  parameter int ALU_READY_POS = ALU_READY_POS_DEF,
  parameter int LD_READY_POS  = LD_READY_POS_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   hold_i,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  input  logic                   issue_wen_i,
  input  logic                   issue_load_i,
  input  logic [AW-1:0]          issue_addr_i,
  input  logic [NUM_READ*AW-1:0] rd_addr_i,
  input  logic [NUM_READ*DW-1:0] rf_data_i,
  input  logic [DEPTH*DW-1:0]    stage_data_i,
  output logic [NUM_READ*DW-1:0] rd_data_o,
  output logic [NUM_READ-1:0]    fwd_hit_o,
  output logic                   stall_o
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            fwd_cnt_o
`endif
);

  entry_t [DEPTH-1:0] entry_reg;
  entry_t [DEPTH-1:0] entry_next;
  logic [NUM_READ-1:0] port_stall;
  logic               issue_accept;

  // A stalled instruction stays in ID, so it must not be recorded yet.
  assign issue_accept = issue_valid_i & issue_wen_i & (issue_addr_i != '0) & ~stall_o;

  always_comb begin
    entry_next = entry_reg;
    if (!hold_i) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        entry_next[k] = entry_reg[k-1];
      end
      entry_next[0].valid = issue_accept & ~flush_i;
      entry_next[0].addr  = ENTRY_AW'(issue_addr_i);
      entry_next[0].load  = issue_load_i;
    end else if (flush_i) begin
      entry_next[0].valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_reg <= '0;
    end else begin
      entry_reg <= entry_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_port
      fwd_port_match #(
        .DEPTH        (DEPTH),
        .AW           (AW),
        .DW           (DW),
        .ALU_READY_POS(ALU_READY_POS),
        .LD_READY_POS (LD_READY_POS)
      ) u_match (
        .entries    (entry_reg),
        .rd_addr    (rd_addr_i[gi*AW +: AW]),
        .rf_data    (rf_data_i[gi*DW +: DW]),
        .stage_data (stage_data_i),
        .data       (rd_data_o[gi*DW +: DW]),
        .hit        (fwd_hit_o[gi]),
        .needs_stall(port_stall[gi])
      );
    end
  endgenerate

  assign stall_o = |port_stall;

`ifdef FWD_STATS_EN
  localparam int POP_W = $clog2(NUM_READ + 1);

  logic [31:0]      stall_cnt_reg;
  logic [31:0]      fwd_cnt_reg;
  logic [POP_W-1:0] hit_pop;
  logic [32:0]      fwd_sum;

  always_comb begin
    hit_pop = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      hit_pop = hit_pop + POP_W'(fwd_hit_o[p]);
    end
    fwd_sum = {1'b0, fwd_cnt_reg} + 33'(hit_pop);
  end

  // Held cycles are not counted: the stall there is caused by memory, not hazards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_reg <= '0;
      fwd_cnt_reg   <= '0;
    end else begin
      if (stall_o && !hold_i && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (issue_valid_i && !stall_o && !hold_i) begin
        fwd_cnt_reg <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign fwd_cnt_o   = fwd_cnt_reg;
`endif

endmodule

// File: tb/tb_id_forwarding_scoreboard.sv
// Self-checking bench: scripted vector table, randomized run against an
// age-based reference model, and an asynchronous mid-operation reset.
module tb_id_forwarding_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, flush, iv, iw, il;
  logic [4:0]  ia;
  logic [9:0]  rd_addr;
  logic [63:0] rf_data;
  logic [95:0] stage_data;
  logic [63:0] rd_data;
  logic [1:0]  fwd_hit;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_forwarding_scoreboard dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .hold_i       (hold),
    .flush_i      (flush),
    .issue_valid_i(iv),
    .issue_wen_i  (iw),
    .issue_load_i (il),
    .issue_addr_i (ia),
    .rd_addr_i    (rd_addr),
    .rf_data_i    (rf_data),
    .stage_data_i (stage_data),
    .rd_data_o    (rd_data),
    .fwd_hit_o    (fwd_hit),
    .stall_o      (stall)
  );

  // Reference model: every accepted write is a record aging one step per
  // unheld edge; it is visible until its age reaches the tracked depth.
  typedef struct {
    logic [4:0] addr;
    bit         load;
    int         age;
  } rec_t;
  rec_t q[$];

  function automatic void model_port(input logic [4:0] ra, input logic [31:0] rf,
                                     input logic [95:0] sd, output bit stl,
                                     output bit hit, output logic [31:0] d);
    int best = -1;
    bit bl = 0;
    stl = 0; hit = 0; d = rf;
    if (ra != 0) begin
      foreach (q[i]) begin
        if (q[i].addr == ra && (best < 0 || q[i].age < best)) begin
          best = q[i].age;
          bl   = q[i].load;
        end
      end
    end
    if (best >= 0) begin
      if (best >= (bl ? 2 : 1)) begin
        hit = 1;
        d   = sd[best*32 +: 32];
      end else begin
        stl = 1;
      end
    end
  endfunction

  function automatic void model_edge(input bit h, input bit f, input bit v, input bit w,
                                     input bit ld, input logic [4:0] a, input bit stl);
    if (!h) begin
      foreach (q[i]) q[i].age++;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].age >= 3) q.delete(i);
      if (v && w && a != 0 && !stl && !f) q.push_back('{a, ld, 0});
    end else if (f) begin
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].age == 0) q.delete(i);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hold = 0; flush = 0; iv = 0; iw = 0; il = 0; ia = '0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
  endtask

  typedef struct {
    bit         hold, flush, iv, iw, il;
    logic [4:0] ia, ra0, ra1;
    logic [31:0] sd1, sd2;
    bit         e_stall;
    bit [1:0]   e_hit;
    int         e_src0, e_src1;
  } vec_t;

  function automatic vec_t mk(bit h, bit f, bit v, bit w, bit ld, logic [4:0] a,
                              logic [4:0] r0, logic [4:0] r1, logic [31:0] s1,
                              logic [31:0] s2, bit es, bit [1:0] eh, int c0, int c1);
    vec_t t;
    t.hold = h; t.flush = f; t.iv = v; t.iw = w; t.il = ld; t.ia = a;
    t.ra0 = r0; t.ra1 = r1; t.sd1 = s1; t.sd2 = s2;
    t.e_stall = es; t.e_hit = eh; t.e_src0 = c0; t.e_src1 = c1;
    return t;
  endfunction

  vec_t vecs[19];

  initial begin
    logic [31:0] rf0, rf1, e0, e1;
    bit s0, s1, h0, h1;
    logic [31:0] d0, d1;

    rst_n = 1'b0;
    hold = 0; flush = 0; iv = 0; iw = 0; il = 0; ia = '0;
    rd_addr = '0; rf_data = '0; stage_data = '0;

    //            h  f  v  w  l  ia  ra0 ra1  sd1           sd2           st hit   s0 s1
    vecs[0]  = mk(0, 0, 1, 1, 0, 5,  5,  0,  32'h1,        32'h2,        0, 2'b00, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,  5,  0,  32'h1,        32'h2,        1, 2'b00, 0, 0);
    vecs[2]  = mk(0, 0, 1, 1, 1, 7,  5,  0,  32'hDEAD_BEEF, 32'h2,       0, 2'b01, 1, 0);
    vecs[3]  = mk(0, 0, 1, 1, 0, 12, 7,  5,  32'h1,        32'hC0DE_0005, 1, 2'b10, 0, 2);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0,  7,  12, 32'h1,        32'h2,        1, 2'b00, 0, 0);
    vecs[5]  = mk(0, 0, 1, 1, 0, 3,  7,  0,  32'h1,        32'h1234_5678, 0, 2'b01, 2, 0);
    vecs[6]  = mk(0, 0, 1, 1, 0, 3,  0,  0,  32'h1,        32'h2,        0, 2'b00, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0,  0,  0,  32'h1,        32'h2,        0, 2'b00, 0, 0);
    vecs[8]  = mk(0, 0, 1, 1, 0, 0,  9,  3,  32'h0000_AAAA, 32'h0000_BBBB, 0, 2'b10, 0, 1);
    vecs[9]  = mk(0, 1, 1, 1, 0, 9,  0,  3,  32'h1,        32'h3333_0003, 0, 2'b10, 0, 2);
    vecs[10] = mk(0, 0, 1, 1, 1, 4,  9,  9,  32'h1,        32'h2,        0, 2'b00, 0, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 0,  4,  0,  32'h1,        32'h2,        1, 2'b00, 0, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 0,  4,  0,  32'h1,        32'h2,        1, 2'b00, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 0, 0,  4,  0,  32'h1,        32'h2,        1, 2'b00, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0,  4,  0,  32'h1,        32'h2,        1, 2'b00, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0,  4,  0,  32'h1,        32'h2,        1, 2'b00, 0, 0);
    vecs[16] = mk(0, 0, 1, 1, 0, 6,  4,  0,  32'h1,        32'h0F0F_0F0F, 0, 2'b01, 2, 0);
    vecs[17] = mk(1, 1, 0, 0, 0, 0,  0,  6,  32'h1,        32'h2,        1, 2'b00, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0,  6,  6,  32'h1,        32'h2,        0, 2'b00, 0, 0);

    do_reset();

    // Scripted sequence: each vector is checked before its edge, then clocked.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      hold = vecs[i].hold; flush = vecs[i].flush;
      iv = vecs[i].iv; iw = vecs[i].iw; il = vecs[i].il; ia = vecs[i].ia;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      rf0 = 32'hA000_0000 | 32'(vecs[i].ra0);
      rf1 = 32'hB000_0000 | 32'(vecs[i].ra1);
      rf_data = {rf1, rf0};
      stage_data = {vecs[i].sd2, vecs[i].sd1, 32'h5555_5555};
      #1;
      e0 = (vecs[i].e_src0 == 0) ? rf0 : (vecs[i].e_src0 == 1) ? vecs[i].sd1 : vecs[i].sd2;
      e1 = (vecs[i].e_src1 == 0) ? rf1 : (vecs[i].e_src1 == 1) ? vecs[i].sd1 : vecs[i].sd2;
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d hit", i), 32'(fwd_hit), 32'(vecs[i].e_hit));
      chk($sformatf("vec%0d data0", i), rd_data[31:0], e0);
      chk($sformatf("vec%0d data1", i), rd_data[63:32], e1);
      $display("vec %0d: ra=%0d/%0d stall=%0b hit=%b d0=%h d1=%h", i,
               vecs[i].ra0, vecs[i].ra1, stall, fwd_hit, rd_data[31:0], rd_data[63:32]);
    end

    do_reset();

    // Randomized run against the reference model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hold  = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) == 0);
      iv = $urandom_range(0, 1); iw = ($urandom_range(0, 3) != 0);
      il = $urandom_range(0, 1); ia = 5'($urandom_range(0, 6));
      rd_addr = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
      rf_data = {$urandom(), $urandom()};
      stage_data = {$urandom(), $urandom(), $urandom()};
      #1;
      model_port(rd_addr[4:0], rf_data[31:0], stage_data, s0, h0, d0);
      model_port(rd_addr[9:5], rf_data[63:32], stage_data, s1, h1, d1);
      chk($sformatf("rnd%0d stall", c), 32'(stall), 32'(s0 | s1));
      chk($sformatf("rnd%0d hit", c), 32'(fwd_hit), 32'({h1, h0}));
      chk($sformatf("rnd%0d data0", c), rd_data[31:0], d0);
      chk($sformatf("rnd%0d data1", c), rd_data[63:32], d1);
      @(posedge clk);
      model_edge(hold, flush, iv, iw, il, ia, s0 | s1);
    end

    // Asynchronous reset while a forwardable entry is in flight.
    do_reset();
    @(negedge clk);
    hold = 0; flush = 0; iv = 1; iw = 1; il = 0; ia = 5'd5;
    rd_addr = {5'd0, 5'd0};
    rf_data = {32'hB000_0000, 32'hA000_0005};
    stage_data = {32'h2, 32'h7777_0001, 32'h0};
    @(negedge clk);
    iv = 0; rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    #1;
    chk("pre_rst hit", 32'(fwd_hit), 32'h1);
    chk("pre_rst data0", rd_data[31:0], 32'h7777_0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst stall", 32'(stall), 32'h0);
    chk("mid_rst hit", 32'(fwd_hit), 32'h0);
    chk("mid_rst data0", rd_data[31:0], 32'hA000_0005);
    $display("mid-op reset: stall=%0b hit=%b d0=%h", stall, fwd_hit, rd_data[31:0]);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst hit", 32'(fwd_hit), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_forwarding_scoreboard.md
Name: id_forwarding_scoreboard

Overview:
- Parametrised ID-stage operand forwarding unit; generalises single-source EX/MEM equality forwarding to NUM_READ ports, DEPTH tracked stages and load-aware readiness.
- Keeps an internal shift register of in-flight writebacks: destination, load flag, stage position.
- Per read port, selects the youngest matching in-flight result, or the register-file value.
- Raises stall_o when the youngest match's data does not exist yet (load-use, ALU-in-EX); replaces external stall logic for branch-compare operands.

Parameters:
- NUM_READ, 2, number of ID read ports.
- DEPTH, 3, tracked stages after ID (pos 0=EX, 1=MEM, 2=WB).
- AW, 5, register address width.
- DW, 32, data width.
- ALU_READY_POS, 1, first position at which a non-load result is valid.
- LD_READY_POS, 2, first position at which load data is valid; must be ≤ DEPTH-1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- hold_i  in  1  global pipeline freeze (memory wait); shift register holds
- flush_i  in  1  kill the entry at pos 0 (wrong-path) at next edge
- issue_valid_i  in  1  instruction leaving ID this cycle
- issue_wen_i  in  1  issued instruction writes a register
- issue_load_i  in  1  issued instruction is a load
- issue_addr_i  in  AW  issued destination register
- rd_addr_i  in  NUM_READ*AW  read addresses, port p at [p*AW +: AW]
- rf_data_i  in  NUM_READ*DW  register-file read data per port
- stage_data_i  in  DEPTH*DW  result currently held at each position
- rd_data_o  out  NUM_READ*DW  forwarded operand per port
- fwd_hit_o  out  NUM_READ  port took data from a stage
- stall_o  out  1  ID must not advance

Behaviour:
- Entry fields: valid, addr, load. Reset: all entries invalid; stall_o=0, fwd_hit_o=0, rd_data_o=rf_data_i.
- Push (posedge, hold_i=0): pos k+1 ← pos k; pos DEPTH-1 is discarded. Pos 0 ← {issue_valid_i & issue_wen_i & addr≠0 & ~stall_o, issue_addr_i, issue_load_i}. Otherwise pos 0 becomes a bubble.
- flush_i: pos 0's new value is forced invalid; the shift of older entries still occurs. flush_i together with hold_i clears pos 0 in place.
- hold_i=1, no flush: all entries unchanged.
- Match for port p: lowest k with valid & addr==rd_addr_p & rd_addr_p≠0. Youngest match wins.
- Ready(k) = k ≥ (load ? LD_READY_POS : ALU_READY_POS).
- Match and ready: rd_data_o[p]=stage_data_i[k], fwd_hit_o[p]=1.
- No match: rd_data_o[p]=rf_data_i[p], fwd_hit_o[p]=0.
- Match not ready: stall_o=1, rd_data_o[p]=rf_data_i[p] (don't-care), fwd_hit_o[p]=0. An older ready match is never used in this case.
- Port outputs are combinational from entries plus inputs (zero latency). State updates at the clock edge only.
- Reset asserted mid-operation clears all entries immediately. Register x0 is never tracked or forwarded.

Optional Feature:
- Macro FWD_STATS_EN.
- Defined: adds stall_cnt_o[31:0] and fwd_cnt_o[31:0]. Both saturate at 2^32-1 and reset to 0. stall_cnt_o increments each cycle with stall_o=1 & hold_i=0. fwd_cnt_o increments by popcount(fwd_hit_o) when issue_valid_i & ~stall_o & ~hold_i.
- Undefined: ports absent, no counter logic.

Decomposition:
- Package fwd_pkg: entry struct typedef (valid, addr, load), ALU/LD ready-position defaults, function ready(pos, load).
- Sub-module fwd_port_match: one instance per read port. Takes entry array, rd_addr, rf_data and stage_data; returns data, hit, needs_stall.

Test Plan:
- Reset, then read x5 with no entries → rd_data_o=rf_data_i, stall_o=0, fwd_hit_o=0.
- Issue ALU write x5; next cycle read x5 (entry at pos 0) → stall_o=1. One cycle later (pos 1, stage_data=0xDEAD_BEEF) → rd_data_o=0xDEAD_BEEF, fwd_hit_o[0]=1.
- Issue load x7; reads of x7 → stall 2 cycles, then forwards stage_data_i[2]=0x1234_5678.
- x3 at pos 1 (ALU, 0xAAAA) and at pos 2 (0xBBBB), port 1 reads x3 → 0xAAAA (youngest wins).
- Issue write to x0, then read x0 → never forwarded, no stall. Issue x9 with flush_i the next edge, then read x9 → no stall, rf data.
- hold_i=1 for 3 cycles with a load at pos 0 → entries frozen, stall persists. Release → normal progression. With FWD_STATS_EN: stall_cnt_o excludes held cycles.
